alu_multiciclo: RTL
===================

Name: alu_multiciclo

Overview:
- Parametrised multi-cycle successor of the single-cycle 32-bit ALU.
- Adds iterative unsigned multiply (shift-add) and unsigned divide (restoring), a start/busy/done handshake, and registered result/flag outputs.
- Sits in the multi-cycle datapath. The control FSM issues `start` and waits on `done`.

Parameters:
- N, 32, operand/result width (N >= 4)
- CW, 6, width of the internal iteration counter (2**CW >= N)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- A  in  N  operand A
- B  in  N  operand B
- ControlloALU  in  3  op: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 div, 110/111 reserved
- Risultato  out  N  result low (sum/logic/product low/quotient)
- RisultatoAlto  out  N  product high (mul) / remainder (div); 0 for other ops
- Negative  out  1  Risultato[N-1]
- Zero  out  1  Risultato == 0
- Carry  out  1  carry flag
- oVerflow  out  1  overflow flag
- DivZero  out  1  last div had B == 0
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async on rst_n=0): FSM=IDLE; all outputs 0; internal registers cleared.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE + start at edge k, op in {add, sub, and, or, reserved, div with B=0}:
    - compute combinationally from A, B;
    - register outputs at edge k;
    - done=1 for the cycle after edge k;
    - stay IDLE, busy stays 0.
  - IDLE + start, op in {mul, div with B!=0}:
    - capture A, B, op at edge k;
    - busy=1, counter=0, state RUN.
  - RUN: one iteration per edge.
    - On the edge where the counter reaches N, register outputs, set busy=0 and done=1 (one cycle), and return to IDLE.
    - Latency is N edges after the start edge.
- Operand/op changes during RUN are ignored. Start during busy=1 is ignored (not queued).
- Back-to-back: start while done=1 and busy=0 is accepted.
- Outputs hold their last values until the next completion.
- Add/sub (sub = A + ~B + 1):
  - Carry = carry-out (1 = no borrow for sub);
  - oVerflow = signed overflow: operand signs (B inverted for sub) equal and result sign differs.
- and/or: Carry=0, oVerflow=0, RisultatoAlto=0.
- mul (unsigned, 2N-bit product): {RisultatoAlto, Risultato} = A*B; Carry = oVerflow = (RisultatoAlto != 0).
- div (unsigned, restoring): Risultato = quotient, RisultatoAlto = remainder; Carry=0, oVerflow=0.
- Div with B=0: Risultato = all ones, RisultatoAlto = A, DivZero=1, latency 1.
- DivZero is cleared by any other completing op.
- Reserved op codes: Risultato=0, RisultatoAlto=0, Zero=1, other flags 0, latency 1.
- Negative and Zero always derive from the registered Risultato only.

Decomposition:
- Package alu_pkg holds:
  - op-code constants OP_ADD..OP_DIV (3 bits);
  - FSM state enum {IDLE, RUN}.
- Sub-module seq_muldiv (parameter N): iterative datapath with
  - accumulator/remainder, multiplicand/divisor and counter registers;
  - inputs load, mode, step; outputs hi, lo, last.
- Top level keeps the FSM, the combinational add/sub/logic path, and the flag/output registers.

Test Plan (N=32):
- Add 0x7FFFFFFF + 0x00000001 -> done 1 cycle after start; Risultato=0x80000000, Negative=1, oVerflow=1, Carry=0, Zero=0.
- Sub 5 - 5 -> Risultato=0, Zero=1, Carry=1, oVerflow=0. Sub 3 - 5 -> 0xFFFFFFFE, Carry=0, Negative=1.
- Mul 0xFFFFFFFF * 2 -> busy high 32 cycles, done at edge k+32; Risultato=0xFFFFFFFE, RisultatoAlto=1, Carry=oVerflow=1. A/B toggled during RUN does not alter the result.
- Div 100 / 7 -> Risultato=14, RisultatoAlto=2, done at k+32. Div 9 / 0 -> done at k+1, Risultato=0xFFFFFFFF, RisultatoAlto=9, DivZero=1. A following add clears DivZero.
- rst_n pulsed low at cycle 10 of a mul -> all outputs 0 immediately, no done. A new add started after reset completes normally.
- Second start while busy=1 is ignored. Start in the done cycle of a mul is accepted, and its done follows at the correct latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_multiciclo_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One iteration per step. hi/lo present the post-step values so the caller
// can register the final result on the same edge as the last iteration.
module seq_muldiv #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         mode,   // 0 = multiply, 1 = divide
    input  logic         step,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         last
);

    logic [N-1:0]  acc;      // product high / partial remainder
    logic [N-1:0]  mq;       // multiplier shifting out / dividend -> quotient
    logic [N-1:0]  md;       // multiplicand / divisor
    logic [CW-1:0] cnt;

    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  mq_nxt;
    logic [N:0]    add_sum;
    logic [N:0]    shifted;
    logic [N-1:0]  sub_lo;
    logic          fits;

    // Single iteration of either algorithm, selected by mode.
    always_comb begin
        acc_nxt = acc;
        mq_nxt  = mq;
        add_sum = {1'b0, acc} + (mq[0] ? {1'b0, md} : {(N+1){1'b0}});
        shifted = {acc, mq[N-1]};
        fits    = (shifted >= {1'b0, md});
        // When the divisor fits, the true difference is below md, so the low
        // N bits are the whole answer.
        sub_lo  = shifted[N-1:0] - md;
        if (mode) begin
            if (fits) begin
                acc_nxt = sub_lo;
                mq_nxt  = {mq[N-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[N-1:0];
                mq_nxt  = {mq[N-2:0], 1'b0};
            end
        end else begin
            acc_nxt = add_sum[N:1];
            mq_nxt  = {add_sum[0], mq[N-1:1]};
        end
    end

    // Operand capture on load, then iterate on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            mq  <= '0;
            md  <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            mq  <= a;
            md  <= b;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    assign hi   = acc_nxt;
    assign lo   = mq_nxt;
    assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative mul/div, registered
// results and flags with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; 1-cycle ops complete directly from here
// RUN   | mul/div iterating, one step per clock; busy=1
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   ControlloALU,
    output logic [N-1:0] Risultato,
    output logic [N-1:0] RisultatoAlto,
    output logic         Negative,
    output logic         Zero,
    output logic         Carry,
    output logic         oVerflow,
    output logic         DivZero,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [2:0]   op_q;

    logic [N-1:0] res_q, alto_q;
    logic         carry_q, ovf_q, zero_q, divz_q, done_q;

    logic [N-1:0] res_d, alto_d;
    logic         carry_d, ovf_d, divz_d, done_d, upd;

    logic         load, step, last;
    logic [N-1:0] md_hi, md_lo;

    logic [N-1:0] b_op;
    logic [N:0]   sum;
    logic         is_sub;

    seq_muldiv #(.N(N), .CW(CW)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .mode  (op_q == OP_DIV),
        .step  (step),
        .a     (A),
        .b     (B),
        .hi    (md_hi),
        .lo    (md_lo),
        .last  (last)
    );

    // Add/sub share one adder: sub is A + ~B + 1.
    always_comb begin
        is_sub = (ControlloALU == OP_SUB);
        b_op   = is_sub ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, is_sub};
    end

    // Next state, datapath control and the values to register on completion.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        upd     = 1'b0;
        done_d  = 1'b0;
        res_d   = '0;
        alto_d  = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        divz_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ControlloALU == OP_MUL || (ControlloALU == OP_DIV && B != '0)) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        upd    = 1'b1;
                        done_d = 1'b1;
                        case (ControlloALU)
                            OP_ADD, OP_SUB: begin
                                res_d   = sum[N-1:0];
                                carry_d = sum[N];
                                ovf_d   = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);
                            end
                            OP_AND: res_d = A & B;
                            OP_OR:  res_d = A | B;
                            OP_DIV: begin
                                res_d  = '1;
                                alto_d = A;
                                divz_d = 1'b1;
                            end
                            default: res_d = '0;
                        endcase
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    upd     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    res_d   = md_lo;
                    alto_d  = md_hi;
                    if (op_q == OP_MUL) begin
                        carry_d = (md_hi != '0);
                        ovf_d   = (md_hi != '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured op, and result/flag registers held until next completion.
    // Zero is captured alongside Risultato so that it reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            alto_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            divz_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                op_q <= ControlloALU;
            end
            if (upd) begin
                res_q   <= res_d;
                alto_q  <= alto_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= (res_d == '0);
                divz_q  <= divz_d;
            end
        end
    end

    assign Risultato     = res_q;
    assign RisultatoAlto = alto_q;
    assign Negative      = res_q[N-1];
    assign Zero          = zero_q;
    assign Carry         = carry_q;
    assign oVerflow      = ovf_q;
    assign DivZero       = divz_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;

endmodule
